arb_mux_reg: RTL and testbench

//   Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/arb_mux_reg.sv | 131 +++++++++++++
 tb/tb_arb_mux_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrating output multiplexer:
// arbitration mode encodings and the output-register state type.
package arb_pkg;

    // Arbitration mode encodings for the 'mode' input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // The output register is either empty or holding one word.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter producing a one-hot grant.
// The request vector is rotated so that the search starts at the
// round-robin pointer (or at index 0 in fixed-priority mode). The lowest
// set bit of the rotated vector is found, and its position is mapped back
// to a channel index by adding the rotation amount modulo N.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant
);

    logic [SW-1:0] base;
    logic [N-1:0]  rot;
    logic          found;
    logic [SW-1:0] rot_idx;
    logic [SW:0]   sum;
    logic [SW-1:0] gidx;

    // Fixed priority is simply round-robin with the search anchored at 0.
    assign base = (mode == MODE_RR) ? ptr : '0;

    // Concatenating req with itself lets a plain right shift act as a
    // rotate; the low N bits hold req starting at index 'base'.
    assign rot = N'({req, req} >> base);

    // Lowest set bit of the rotated vector; iterating downwards lets the
    // lowest index overwrite any higher one.
    always_comb begin
        found   = 1'b0;
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found   = 1'b1;
                rot_idx = SW'(i);
            end
        end
    end

    // Undo the rotation: winning channel = (rot_idx + base) mod N.
    always_comb begin
        sum = {1'b0, rot_idx} + {1'b0, base};
        if (sum >= (SW + 1)'(N)) begin
            sum = sum - (SW + 1)'(N);
        end
        gidx = sum[SW-1:0];
    end

    // One-hot grant, all zero when nobody is requesting.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (gidx == SW'(i));
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating multiplexer with a single registered output stage.
// Several valid/ready producers compete for one consumer port; the winner
// of the combinational arbiter is loaded into the output register, tagged
// with its channel index. A full register that is being drained can be
// refilled on the same edge, giving one word per cycle sustained.
module arb_mux_reg
    import arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ready
);

    out_state_t       state_q;
    out_state_t       state_d;
    logic [N-1:0]     grant;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    gnt_idx;
    logic [SW-1:0]    rr_ptr;
    logic [SW-1:0]    rr_ptr_next;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    src_q;

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .mode  (mode),
        .grant (grant)
    );

    assign out_valid = (state_q == OUT_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

    // The register can accept a word when empty or when its content is
    // leaving this cycle. Gating with rst_n keeps every in_ready low while
    // reset is held, even though the emptied register would otherwise
    // advertise space.
    assign load_en  = ~out_valid | out_ready;
    assign in_ready = grant & {N{load_en & rst_n}};
    assign xfer     = |in_ready;

    // AND-OR select of the granted channel's word plus the binary index of
    // the granted channel; grant is one-hot so the ORs never collide.
    always_comb begin
        sel_data = '0;
        gnt_idx  = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            if (grant[i]) begin
                gnt_idx = gnt_idx | SW'(i);
            end
        end
    end

    // Next round-robin start point: one past the channel just served.
    always_comb begin
        if (gnt_idx == SW'(N - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = gnt_idx + SW'(1);
        end
    end

    // Output register occupancy: a transfer always leaves it full, a
    // drain without a refill empties it, otherwise it holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (xfer) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (xfer) begin
                    state_d = OUT_FULL;
                end else if (out_ready) begin
                    state_d = OUT_EMPTY;
                end
            end
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data and source tag load only on a transfer; a drain leaves the last
    // word visible on out_data/out_src.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            src_q  <= '0;
        end else if (xfer) begin
            data_q <= sel_data;
            src_q  <= gnt_idx;
        end
    end

    // The pointer advances on every transfer in both modes so that a switch
    // to round-robin continues from the most recently served channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: stimulus pushes the expected output word
// and source into a queue; an independent monitor pops and compares on
// every output handshake.
module tb_arb_mux_reg;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SW    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_src;
    logic                 out_ready;

    typedef struct packed {
        logic [SW-1:0]    src;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t expQ[$];
    exp_t popped;
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] chData [N];

    arb_mux_reg #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Keep the packed data bus in step with the per-channel table.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_data[i*WIDTH +: WIDTH] = chData[i];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [N-1:0] v, input logic ordy);
        mode      = m;
        in_valid  = v;
        out_ready = ordy;
    endtask

    task automatic pushExpect(input logic [SW-1:0] s, input logic [WIDTH-1:0] d);
        exp_t e;
        e.src  = s;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every negedge where the consumer handshake is set up, the
    // word about to leave is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got src %0d data %h, expected none", out_src, out_data);
            end else begin
                popped = expQ.pop_front();
                checkOutput("mon_src", 32'(out_src), 32'(popped.src));
                checkOutput("mon_data", out_data, popped.data);
            end
        end
    end

    initial begin
        chData[0] = 32'h000000C0;
        chData[1] = 32'h00000011;
        chData[2] = 32'h00000022;
        chData[3] = 32'h00000033;

        // Reset held with every channel requesting.
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_out_src", 32'(out_src), 32'h0);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        #1;
        checkOutput("rst_in_ready_rr", 32'(in_ready), 32'h0);

        // Release: first grant is ch0 in both modes.
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'b1111, 1'b1);
        #1;
        checkOutput("rel_grant_fixed", 32'(in_ready), 32'h1);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        #1;
        checkOutput("rel_grant_rr", 32'(in_ready), 32'h1);

        // Round-robin with all channels requesting: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
            pushExpect(SW'(k % 4), chData[k % 4]);
            tick();
            checkOutput("rr_out_valid", 32'(out_valid), 32'h1);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        checkOutput("rr_drained", 32'(out_valid), 32'h0);

        // Fixed priority: ch1 always beats ch3.
        applyStimulus(1'b0, 4'b1010, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("fix_in_ready", 32'(in_ready), 32'h2);
            pushExpect(2'd1, 32'h11);
            tick();
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("fix_drained", 32'(out_valid), 32'h0);

        // Backpressure: hold 0xDEAD for three cycles, then drain and refill
        // on the same edge.
        chData[2] = 32'h0000DEAD;
        applyStimulus(1'b0, 4'b0100, 1'b1);
        pushExpect(2'd2, 32'h0000DEAD);
        tick();
        applyStimulus(1'b0, 4'b0001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
            checkOutput("bp_out_data", out_data, 32'h0000DEAD);
            checkOutput("bp_out_valid", 32'(out_valid), 32'h1);
            tick();
        end
        applyStimulus(1'b0, 4'b0001, 1'b1);
        #1;
        checkOutput("bp_refill_ready", 32'(in_ready), 32'h1);
        pushExpect(2'd0, 32'h000000C0);
        tick();
        checkOutput("bp_no_bubble", 32'(out_valid), 32'h1);
        checkOutput("bp_new_data", out_data, 32'h000000C0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        tick();
        chData[2] = 32'h00000022;

        // Wrap: serve ch2 to leave the pointer at 3, then round-robin over
        // channels 0 and 1 must wrap to ch0 first.
        applyStimulus(1'b0, 4'b0100, 1'b1);
        pushExpect(2'd2, 32'h22);
        tick();
        applyStimulus(1'b1, 4'b0011, 1'b1);
        #1;
        checkOutput("wrap_grant0", 32'(in_ready), 32'h1);
        pushExpect(2'd0, 32'h000000C0);
        tick();
        checkOutput("wrap_grant1", 32'(in_ready), 32'h2);
        pushExpect(2'd1, 32'h11);
        tick();
        applyStimulus(1'b1, 4'b0000, 1'b1);
        #1;
        checkOutput("sparse_no_grant", 32'(in_ready), 32'h0);
        tick();
        checkOutput("sparse_empty", 32'(out_valid), 32'h0);
        checkOutput("sparse_hold_data", out_data, 32'h11);
        checkOutput("sparse_hold_src", 32'(out_src), 32'h1);

        // Asynchronous reset while full: the loaded word is dropped and the
        // pointer restarts at ch0.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        #1;
        checkOutput("ar_grant_pre", 32'(in_ready), 32'h4);
        tick();
        checkOutput("ar_full", 32'(out_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_out_valid", 32'(out_valid), 32'h0);
        checkOutput("ar_out_data", out_data, 32'h0);
        checkOutput("ar_in_ready", 32'(in_ready), 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("ar_first_grant", 32'(in_ready), 32'h1);
        pushExpect(2'd0, 32'h000000C0);
        tick();
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        tick();

        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
